// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL lock sequencer with core reset, 32 MHz enable and loss count; PLL re-reset on timeout when PLL_RESET_SEQ_RELOCK_EN is defined
module pll_reset_seq #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int PLL_TIMEOUT    = 65536,
  parameter int PLL_RST_CYCLES = 16,
  parameter int CEN_DIV        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       cen,
  output logic [7:0] lock_loss_cnt
);
  localparam int SW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  localparam int DW = CEN_DIV > 1 ? $clog2(CEN_DIV) : 1;
  localparam logic [SW-1:0] SMAX = SW'(LOCK_CYCLES - 1);
  localparam logic [DW-1:0] DMAX = DW'(CEN_DIV - 1);
  typedef enum logic [1:0] {WAIT, SETTLE, RUN, PLLRST} state_t;
  state_t state, state_n;
  logic sync1, locked_s;
  logic [SW-1:0] scnt, scnt_n;
  logic [DW-1:0] div, div_n;
  logic [7:0] loss_n;
`ifdef PLL_RESET_SEQ_RELOCK_EN
  localparam int TW = PLL_TIMEOUT > 1 ? $clog2(PLL_TIMEOUT) : 1;
  localparam int RW = PLL_RST_CYCLES > 1 ? $clog2(PLL_RST_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(PLL_TIMEOUT - 1);
  localparam logic [RW-1:0] RMAX = RW'(PLL_RST_CYCLES - 1);
  logic [TW-1:0] tcnt, tcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt    <= '0;
      rcnt    <= '0;
      pll_rst <= 1'b0;
    end else begin
      tcnt    <= tcnt_n;
      rcnt    <= rcnt_n;
      pll_rst <= state == PLLRST;
    end
  end
`else
  assign pll_rst = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= WAIT;
      sync1         <= 1'b0;
      locked_s      <= 1'b0;
      scnt          <= '0;
      div           <= '0;
      lock_loss_cnt <= '0;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      cen           <= 1'b0;
    end else begin
      state         <= state_n;
      sync1         <= pll_locked;
      locked_s      <= sync1;
      scnt          <= scnt_n;
      div           <= div_n;
      lock_loss_cnt <= loss_n;
      sys_rst       <= state != RUN;
      ready         <= state == RUN;
      cen           <= state == RUN && div == '0;
    end
  end
  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    div_n   = '0;
    loss_n  = lock_loss_cnt;
`ifdef PLL_RESET_SEQ_RELOCK_EN
    tcnt_n  = tcnt;
    rcnt_n  = '0;
`endif
    case (state)
      WAIT: begin
        scnt_n = '0;
        if (locked_s) state_n = SETTLE;
`ifdef PLL_RESET_SEQ_RELOCK_EN
        if (locked_s) tcnt_n = '0;
        else if (tcnt == TMAX) state_n = PLLRST;
        else tcnt_n = tcnt + 1'b1;
`endif
      end
      SETTLE: begin
        if (!locked_s) begin
          state_n = WAIT;
          scnt_n  = '0;
`ifdef PLL_RESET_SEQ_RELOCK_EN
          tcnt_n  = '0;
`endif
        end else if (scnt == SMAX) state_n = RUN;
        else scnt_n = scnt + 1'b1;
      end
      RUN: begin
        if (!locked_s) begin
          state_n = WAIT;
          loss_n  = lock_loss_cnt + {7'd0, lock_loss_cnt != 8'hff};
        end else div_n = div == DMAX ? '0 : div + 1'b1;
      end
`ifdef PLL_RESET_SEQ_RELOCK_EN
      PLLRST: begin
        if (rcnt == RMAX) begin
          state_n = WAIT;
          tcnt_n  = '0;
        end else rcnt_n = rcnt + 1'b1;
      end
`endif
      default: state_n = WAIT;
    endcase
  end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: random lock patterns against a lock-streak reference model
module tb_pll_reset_seq;
  localparam int LC = 8;
  localparam int PT = 32;
  localparam int PR = 4;
  localparam int CD = 3;
  logic clk = 1'b0;
  logic rst_n, pll_locked;
  logic pll_rst, sys_rst, ready, cen;
  logic [7:0] lock_loss_cnt;
  int total = 0;
  int bad = 0;
  int m_s1, m_ls, m_streak, m_run, m_runpos, m_loss;
  int e_sys = 1, e_cen = 0, e_pll = 0;
  pll_reset_seq #(.LOCK_CYCLES(LC), .PLL_TIMEOUT(PT), .PLL_RST_CYCLES(PR), .CEN_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .ready(ready), .cen(cen), .lock_loss_cnt(lock_loss_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic pl, input logic rn);
    int streak_n, run_n, runpos_n;
    @(negedge clk);
    pll_locked = pl;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      m_s1 = 0; m_ls = 0; m_streak = 0; m_run = 0; m_runpos = 0; m_loss = 0;
      e_sys = 1; e_cen = 0;
    end else begin
      streak_n = m_ls ? (m_streak < 100000 ? m_streak + 1 : m_streak) : 0;
      run_n = streak_n >= LC + 1;
      runpos_n = (run_n && m_run) ? m_runpos + 1 : 0;
      e_sys = !m_run;
      e_cen = m_run && (m_runpos % CD == 0);
      if (m_run && !m_ls && m_loss < 255) m_loss++;
      m_ls = m_s1; m_s1 = pl; m_streak = streak_n; m_run = run_n; m_runpos = runpos_n;
    end
    #1;
    chk("sys_rst", sys_rst, e_sys);
    chk("ready", ready, !e_sys);
    chk("cen", cen, e_cen);
    chk("pll_rst", pll_rst, e_pll);
    chk("lock_loss_cnt", lock_loss_cnt, m_loss);
  endtask
  task automatic lock_latency(input string tag);
    int k = 0;
    step(1, 1);
    while (sys_rst && k < 40) begin
      step(1, 1);
      k++;
    end
    chk(tag, k, 11);
  endtask
  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b0;
    repeat (3) step(0, 0);
    repeat (3) step(0, 1);
    lock_latency("lock_latency");
    repeat (20) step(1, 1);
    repeat (5) step(0, 1);
    repeat (5) step(1, 1);
    repeat (3) step(0, 1);
    lock_latency("relock_after_glitch");
    repeat (10) step(1, 1);
    step(1, 0);
    chk("rst_in_run_sys_rst", sys_rst, 1);
    chk("rst_in_run_cen", cen, 0);
    repeat (150) begin
      int hi = $urandom_range(0, 1) ? $urandom_range(1, 12) : $urandom_range(12, 60);
      int lo = $urandom_range(1, 20);
      repeat (hi) step(1, 1);
      repeat (lo) step(0, 1);
    end
    repeat (300) begin
      repeat (LC + 6) step(1, 1);
      repeat (2) step(0, 1);
    end
    chk("loss_saturated", lock_loss_cnt, 255);
    step(0, 0);
`ifdef PLL_RESET_SEQ_RELOCK_EN
    for (int k = 1; k <= 142; k++) begin
      e_pll = (k >= 33 && (k - 33) % (PT + PR) < PR) ? 1 : 0;
      step(0, 1);
    end
    chk("pll_rst_before_abort", pll_rst, 1);
    e_pll = 0;
    step(0, 0);
    chk("rst_in_pllrst_pll_rst", pll_rst, 0);
    chk("rst_in_pllrst_loss", lock_loss_cnt, 0);
`else
    repeat (1000) step(0, 1);
    chk("no_relock_pll_rst", pll_rst, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The module SHALL have parameter LOCK_CYCLES, default 1024: the number of consecutive cycles the lock must hold before the core is released.
REQ-002 The module SHALL have parameter PLL_TIMEOUT, default 65536: the number of cycles spent waiting for lock before the PLL is re-reset.
REQ-003 The module SHALL have parameter PLL_RST_CYCLES, default 16: the width of the pll_rst pulse, in cycles.
REQ-004 The module SHALL have parameter CEN_DIV, default 3: the clock-enable divide ratio, giving a 96 to 32 MHz enable.
REQ-005 The module SHALL have input clk, 1 bit: the 96 MHz system clock (PLL outclk_0).
REQ-006 The module SHALL have input rst_n, 1 bit: reset, synchronous, active-low.
REQ-007 The module SHALL have input pll_locked, 1 bit: the PLL locked indication, asynchronous to clk.
REQ-008 The module SHALL have output pll_rst, 1 bit: the active-high reset request to the PLL rst input.
REQ-009 The module SHALL have output sys_rst, 1 bit: the active-high core reset.
REQ-010 The module SHALL have output ready, 1 bit: high while the core runs; ready is the inverse of sys_rst.
REQ-011 The module SHALL have output cen, 1 bit: a one-cycle clock-enable pulse every CEN_DIV cycles.
REQ-012 The module SHALL have output lock_loss_cnt, 8 bits: a saturating count of lock losses that occur in RUN.

Function
REQ-013 The module SHALL pass pll_locked through a two-flop synchronizer; only the second flop output (locked_s) SHALL be used.
REQ-014 The FSM SHALL have exactly the states WAIT, SETTLE, RUN and PLLRST, held in a single state register.
REQ-015 sys_rst, ready and pll_rst SHALL be decoded from the state register only, with no combinational path from inputs.
REQ-016 In WAIT: locked_s=1 SHALL cause a transition to SETTLE with the settle counter cleared to 0.
REQ-017 In WAIT: the timeout counter SHALL increment every cycle while locked_s=0.
REQ-018 In SETTLE: the settle counter SHALL increment every cycle.
REQ-019 In SETTLE: locked_s=0 SHALL return the FSM to WAIT and clear both counters.
REQ-020 In SETTLE: when the settle counter equals LOCK_CYCLES-1 and locked_s=1, the FSM SHALL move to RUN.
REQ-021 In RUN: sys_rst SHALL be 0 and ready SHALL be 1.
REQ-022 In RUN: locked_s=0 SHALL move the FSM to WAIT and increment lock_loss_cnt, saturating at 255.
REQ-023 sys_rst SHALL be 1 in every state other than RUN.
REQ-024 pll_rst SHALL be 1 only in PLLRST.
REQ-025 After PLLRST has lasted PLL_RST_CYCLES cycles, the FSM SHALL return to WAIT with the timeout counter cleared.
REQ-026 The cen divider SHALL be held at 0 outside RUN, so cen=0 outside RUN.
REQ-027 cen SHALL be 1 on the first RUN cycle and every CEN_DIV cycles thereafter; the divider wraps from CEN_DIV-1 to 0.
REQ-028 Counter widths SHALL be $clog2 of their parameter; the settle and timeout counters SHALL never wrap.
REQ-029 A locked_s glitch shorter than LOCK_CYCLES during SETTLE SHALL restart the full settle interval.
REQ-030 If a lock loss in RUN coincides with a cen pulse, that cen pulse SHALL still be emitted, and cen SHALL be 0 from the next cycle.

Reset
REQ-031 While rst_n=0 at a clk edge, the FSM SHALL enter WAIT and all counters, both synchronizer flops and lock_loss_cnt SHALL be cleared to 0.
REQ-032 During reset, outputs SHALL be: sys_rst=1, ready=0, pll_rst=0, cen=0, lock_loss_cnt=0.
REQ-033 Assertion of rst_n mid-operation, in any state including PLLRST, SHALL abort that state on the same edge.

Configuration
REQ-034 When PLL_RESET_SEQ_RELOCK_EN is defined: in WAIT, when the timeout counter equals PLL_TIMEOUT-1 with locked_s=0, the FSM SHALL enter PLLRST.
REQ-035 When PLL_RESET_SEQ_RELOCK_EN is undefined: PLLRST SHALL be unreachable, pll_rst SHALL be constant 0, the timeout counter SHALL be omitted, and WAIT SHALL wait indefinitely.

Verification (LOCK_CYCLES=8, PLL_TIMEOUT=32, PLL_RST_CYCLES=4, CEN_DIV=3)
REQ-036 pll_locked rises and stays high -> sys_rst falls exactly 11 edges after the first edge sampling pll_locked=1; cen=1 on that RUN cycle and every 3rd cycle thereafter.
REQ-037 pll_locked pulses high for 5 cycles during SETTLE -> the FSM returns to WAIT; a subsequent stable lock requires the full 8-cycle settle again; sys_rst is never 0 in between.
REQ-038 pll_locked drops in RUN -> sys_rst=1 three edges later; cen=0 thereafter; lock_loss_cnt increments by 1; 300 such drops -> lock_loss_cnt=255.
REQ-039 RELOCK_EN defined, pll_locked held 0 -> pll_rst high for exactly 4 cycles, starting 32 cycles after WAIT entry, then repeating every 36 cycles.
REQ-040 RELOCK_EN undefined, pll_locked held 0 for 1000 cycles -> pll_rst stays 0 and the FSM stays in WAIT.
REQ-041 rst_n=0 asserted in RUN and in PLLRST -> next edge: sys_rst=1, pll_rst=0, cen=0, lock_loss_cnt=0.
